// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree with per-group channel accumulation.
// NUM_INPUTS products plus one bias leaf are reduced over TREE_LAT registered
// levels; a final stage accumulates beats and emits a saturated/ReLU'd result.
module adder_tree_acc #(
  parameter int INPUT_WIDTH  = 16,
  parameter int BIAS_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 20,
  parameter int NUM_INPUTS   = 9,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic                              relu_en,
  input  logic [BIAS_WIDTH-1:0]             bias_input,
  input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] product_input,
  output logic [OUTPUT_WIDTH-1:0]           ofm_output,
  output logic                              out_valid,
  output logic                              out_sat
);

  localparam int LEAVES   = NUM_INPUTS + 1;
  localparam int TREE_LAT = $clog2(NUM_INPUTS + 1);

  // Output clamp bounds, sign-extended to the accumulator width for compares.
  localparam logic signed [ACC_WIDTH-1:0] OMAX =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0] OMAX_O = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] OMIN_O = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  // Node count at tree level l (level 0 = leaves); halves with round-up.
  function automatic int nodes_at(input int l);
    int n;
    n = LEAVES;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Adder tree. Level 0 is combinational (sign-extended leaves); levels
  // 1..TREE_LAT are registered. An odd trailing node is passed through a
  // register so every path has identical latency.
  // ---------------------------------------------------------------------------
  genvar l, j;
  for (l = 0; l <= TREE_LAT; l++) begin : g_lvl
    localparam int N = nodes_at(l);
    logic signed [ACC_WIDTH-1:0] node [N];

    if (l == 0) begin : g_leaf
      // Sign-extend products; bias leaf only contributes on the first beat.
      always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++)
          node[i] = {{(ACC_WIDTH-INPUT_WIDTH){product_input[i*INPUT_WIDTH+INPUT_WIDTH-1]}},
                     product_input[i*INPUT_WIDTH +: INPUT_WIDTH]};
        node[NUM_INPUTS] = in_first ?
          {{(ACC_WIDTH-BIAS_WIDTH){bias_input[BIAS_WIDTH-1]}}, bias_input} : '0;
      end
    end else begin : g_red
      localparam int NP = nodes_at(l - 1);
      for (j = 0; j < N; j++) begin : g_n
        if (2*j + 1 < NP) begin : g_add
          // Pairwise sum of the two children from the previous level.
          always_ff @(posedge clk or posedge rst)
            if (rst) node[j] <= '0;
            else     node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
        end else begin : g_pass
          // Unpaired child: delay only, keeps tree depth uniform.
          always_ff @(posedge clk or posedge rst)
            if (rst) node[j] <= '0;
            else     node[j] <= g_lvl[l-1].node[2*j];
        end
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] tree_sum;
  assign tree_sum = g_lvl[TREE_LAT].node[0];

  // ---------------------------------------------------------------------------
  // Tag pipeline, aligned stage-for-stage with the tree levels.
  // ---------------------------------------------------------------------------
  logic [TREE_LAT:1] vld_pipe, first_pipe, last_pipe, relu_pipe;

  // Shift the beat tags alongside the data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      relu_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[TREE_LAT-1:1],   in_valid};
      first_pipe <= {first_pipe[TREE_LAT-1:1], in_first};
      last_pipe  <= {last_pipe[TREE_LAT-1:1],  in_last};
      relu_pipe  <= {relu_pipe[TREE_LAT-1:1],  relu_en};
    end

  logic t_vld, t_first, t_last, t_relu;
  assign t_vld   = vld_pipe[TREE_LAT];
  assign t_first = first_pipe[TREE_LAT];
  assign t_last  = last_pipe[TREE_LAT];
  assign t_relu  = relu_pipe[TREE_LAT];

  // ---------------------------------------------------------------------------
  // Accumulate and finalize.
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic                        relu_q, relu_eff;
  logic [OUTPUT_WIDTH-1:0]     res;
  logic                        res_sat;

  // Restart on first, then saturate/ReLU the running total for emission.
  always_comb begin
    acc_next = (t_first ? '0 : acc) + tree_sum;
    relu_eff = t_first ? t_relu : relu_q;
    res      = acc_next[OUTPUT_WIDTH-1:0];
    res_sat  = 1'b0;
    if (relu_eff && acc_next < 0) begin
      res = '0;
    end else if (acc_next > OMAX) begin
      res     = OMAX_O;
      res_sat = 1'b1;
    end else if (acc_next < OMIN) begin
      res     = OMIN_O;
      res_sat = 1'b1;
    end
  end

  // Accumulator, latched ReLU mode and registered result; bubbles are ignored.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc        <= '0;
      relu_q     <= 1'b0;
      ofm_output <= '0;
      out_valid  <= 1'b0;
      out_sat    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (t_vld) begin
        if (t_first) relu_q <= t_relu;
        if (t_last) begin
          acc        <= '0;
          ofm_output <= res;
          out_sat    <= res_sat;
          out_valid  <= 1'b1;
        end else begin
          acc <= acc_next;
        end
      end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: stimulus pushes hand-computed results
// with their due cycle; an independent monitor pops on every out_valid.
module tb_adder_tree_acc;
  localparam int IW  = 16;
  localparam int BW  = 8;
  localparam int OW  = 20;
  localparam int NI  = 9;
  localparam int LAT = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, relu_en = 1'b0;
  logic [BW-1:0]     bias_input = '0;
  logic [NI*IW-1:0]  product_input = '0;
  logic [OW-1:0]     ofm_output;
  logic              out_valid, out_sat;

  adder_tree_acc #(.INPUT_WIDTH(IW), .BIAS_WIDTH(BW), .OUTPUT_WIDTH(OW),
                   .NUM_INPUTS(NI), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .relu_en(relu_en), .bias_input(bias_input),
    .product_input(product_input), .ofm_output(ofm_output),
    .out_valid(out_valid), .out_sat(out_sat));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ofm; bit sat; int due; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected result, on time.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        cmp("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp("ofm", int'($signed(ofm_output)), e.ofm);
        cmp("sat", int'(out_sat), int'(e.sat));
        cmp("latency", cyc, e.due);
      end
    end
  end

  function automatic logic [NI*IW-1:0] all_p(input int v);
    logic [NI*IW-1:0] p;
    for (int i = 0; i < NI; i++) p[i*IW +: IW] = IW'(v);
    return p;
  endfunction

  task automatic expect_res(input int ofm, input bit sat);
    exp_t e;
    e.ofm = ofm; e.sat = sat; e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic beat(input bit f, input bit l, input bit r, input int bias,
                      input logic [NI*IW-1:0] p);
    in_valid = 1'b1; in_first = f; in_last = l; relu_en = r;
    bias_input = BW'(bias); product_input = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    product_input = all_p(7); bias_input = 8'h55;   // junk on bubbles
    repeat (n) @(negedge clk);
  endtask

  task automatic drain;
    int budget;
    budget = 40;
    idle(1);
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    cmp("drain_outstanding", sb.size(), 0);
  endtask

  logic [NI*IW-1:0] p19;

  initial begin
    for (int i = 0; i < NI; i++) p19[i*IW +: IW] = IW'(i + 1);

    // Reset state.
    repeat (3) @(negedge clk);
    cmp("rst_ofm", int'(ofm_output), 0);
    cmp("rst_valid", int'(out_valid), 0);
    cmp("rst_sat", int'(out_sat), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single-beat group, 1 + (1+..+9).
    expect_res(46, 0);
    beat(1, 1, 0, 1, p19);
    drain();

    // 2: three beats of 900, bias -5; immediately followed by a second group.
    beat(1, 0, 0, -5, all_p(100));
    beat(0, 0, 0, 99, all_p(100));          // bias ignored without first
    expect_res(2695, 0);
    beat(0, 1, 0, 99, all_p(100));
    expect_res(46, 0);
    beat(1, 1, 0, 1, p19);                  // back-to-back group
    drain();

    // 3: same with 2 idle clocks between beats.
    beat(1, 0, 0, -5, all_p(100)); idle(2);
    beat(0, 0, 0, 0, all_p(100));  idle(2);
    expect_res(2695, 0);
    beat(0, 1, 0, 0, all_p(100));
    drain();

    // 4: positive and negative saturation over 8 beats.
    for (int b = 0; b < 8; b++) begin
      if (b == 7) expect_res(524287, 1);
      beat(b == 0, b == 7, 0, 0, all_p(32767));
    end
    for (int b = 0; b < 8; b++) begin
      if (b == 7) expect_res(-524288, 1);
      beat(b == 0, b == 7, 0, 0, all_p(-32768));
    end
    drain();

    // 5: ReLU clamps, and is not saturation; without ReLU -10-9 = -19.
    expect_res(0, 0);
    beat(1, 1, 1, -10, all_p(-1));
    expect_res(-19, 0);
    beat(1, 1, 0, -10, all_p(-1));
    // ReLU mode comes from the first beat only: -10-9-9 -> 0.
    beat(1, 0, 1, -10, all_p(-1));
    expect_res(0, 0);
    beat(0, 1, 0, 0, all_p(-1));
    // Restart on a second first: earlier 900 discarded, 1 + 18 = 19.
    beat(1, 0, 0, 0, all_p(100));
    expect_res(19, 0);
    beat(1, 1, 0, 1, all_p(2));
    // Beat after last without first: no bias, 9*3 = 27.
    expect_res(27, 0);
    beat(0, 1, 0, 50, all_p(3));
    drain();

    // 6: reset after beat 2 of 3; outputs clear at once, no pulse follows.
    expect_res(-19, 0);
    beat(1, 1, 0, -10, all_p(-1));
    drain();
    beat(1, 0, 0, -5, all_p(100));
    beat(0, 0, 0, 0, all_p(100));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    cmp("midrst_ofm", int'($signed(ofm_output)), 0);
    cmp("midrst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(LAT + 3);
    expect_res(46, 0);
    beat(1, 1, 0, 1, p19);
    drain();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
